// File: rtl/conway_cell_logic.sv
// Game of Life cell: B3/S23 rule over eight neighbour bits.
// Ports: clk, rst_n (sync, active-low), ena, in[7:0], prev_state -> neighbor_count[3:0], next_state, state_q.
module conway_cell_logic #(
  parameter logic RESET_STATE = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] in,
  input  logic       prev_state,
  output logic [3:0] neighbor_count,
  output logic       next_state,
  output logic       state_q
);

  logic [1:0] sum_l0_0;
  logic [1:0] sum_l0_1;
  logic [1:0] sum_l0_2;
  logic [1:0] sum_l0_3;
  logic [2:0] sum_l1_0;
  logic [2:0] sum_l1_1;
  logic       is_two;
  logic       is_three;

  // Balanced adder tree; each level widens by one bit so 8 fits.
  assign sum_l0_0 = {1'b0, in[0]} + {1'b0, in[1]};
  assign sum_l0_1 = {1'b0, in[2]} + {1'b0, in[3]};
  assign sum_l0_2 = {1'b0, in[4]} + {1'b0, in[5]};
  assign sum_l0_3 = {1'b0, in[6]} + {1'b0, in[7]};

  assign sum_l1_0 = {1'b0, sum_l0_0} + {1'b0, sum_l0_1};
  assign sum_l1_1 = {1'b0, sum_l0_2} + {1'b0, sum_l0_3};

  assign neighbor_count = {1'b0, sum_l1_0} + {1'b0, sum_l1_1};

  assign is_two   = (neighbor_count == 4'd2);
  assign is_three = (neighbor_count == 4'd3);

  // Three neighbours always live; two keep the current value.
  assign next_state = is_three | (is_two & prev_state);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RESET_STATE;
    end else if (ena) begin
      state_q <= next_state;
    end
  end

endmodule

// File: tb/tb_conway_cell_logic.sv
// Self-checking bench for conway_cell_logic.
// Exhaustive truth table, directed cases, then randomized register run.
module tb_conway_cell_logic;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] in;
  logic       prev_state;
  logic [3:0] neighbor_count;
  logic       next_state;
  logic       state_q;

  int n_assert;
  int n_fail;
  logic model_q;

  conway_cell_logic #(.RESET_STATE(1'b0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ena            (ena),
    .in             (in),
    .prev_state     (prev_state),
    .neighbor_count (neighbor_count),
    .next_state     (next_state),
    .state_q        (state_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pop(input logic [7:0] v);
    int c;
    c = 0;
    for (int b = 0; b < 8; b++) c += int'(v[b]);
    return c;
  endfunction

  function automatic logic rule(input logic [7:0] v, input logic p);
    int c;
    c = pop(v);
    if (c == 3) return 1'b1;
    if (c == 2) return p;
    return 1'b0;
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_comb(input string tag);
    check({tag, ".count"}, int'(neighbor_count), pop(in));
    check({tag, ".next"}, int'(next_state), int'(rule(in, prev_state)));
  endtask

  task automatic drive(input logic r, input logic e,
                       input logic [7:0] v, input logic p);
    rst_n = r;
    ena = e;
    in = v;
    prev_state = p;
    #1;
  endtask

  // Advance one edge, update the model, and sample just after.
  task automatic step();
    @(posedge clk);
    if (!rst_n) model_q = 1'b0;
    else if (ena) model_q = rule(in, prev_state);
    #1;
  endtask

  initial begin
    logic [8:0] vec;
    n_assert = 0;
    n_fail = 0;
    model_q = 1'b0;
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    @(negedge clk);

    for (int i = 0; i < 512; i++) begin
      vec = 9'(i);
      drive(1'b1, 1'b0, vec[7:0], vec[8]);
      check_comb("sweep");
    end

    drive(1'b1, 1'b0, 8'b0000_0111, 1'b0);
    check("birth", int'(next_state), 1);
    drive(1'b1, 1'b0, 8'b1000_0001, 1'b1);
    check("survive", int'(next_state), 1);
    drive(1'b1, 1'b0, 8'b1000_0001, 1'b0);
    check("two_dead", int'(next_state), 0);
    drive(1'b1, 1'b0, 8'b0000_0001, 1'b1);
    check("under", int'(next_state), 0);
    drive(1'b1, 1'b0, 8'b0000_1111, 1'b1);
    check("over", int'(next_state), 0);
    drive(1'b1, 1'b0, 8'hFF, 1'b1);
    check("ff.count", int'(neighbor_count), 8);
    check("ff.next", int'(next_state), 0);
    drive(1'b1, 1'b0, 8'h00, 1'b1);
    check("zero.count", int'(neighbor_count), 0);
    check("zero.next", int'(next_state), 0);

    drive(1'b0, 1'b0, 8'h00, 1'b0);
    step();
    check("reset", int'(state_q), 0);
    drive(1'b1, 1'b1, 8'b0001_0101, 1'b0);
    step();
    check("load", int'(state_q), 1);
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    step();
    check("hold", int'(state_q), 1);
    drive(1'b0, 1'b1, 8'b0000_0111, 1'b0);
    check("rst_comb", int'(next_state), 1);
    step();
    check("rst_prio", int'(state_q), 0);
    check("rst_comb_after", int'(next_state), 1);

    for (int k = 0; k < 300; k++) begin
      drive(($urandom_range(0, 9) != 0), 1'($urandom),
            8'($urandom), 1'($urandom));
      check_comb("rand");
      step();
      check("rand.q", int'(state_q), int'(model_q));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
